// File: rtl/bht_predictor_pkg.sv
// Shared types and encodings for the 2-bit branch history table predictor.
package bht_predictor_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'b00;
  localparam ctr2_t WNT = 2'b01;
  localparam ctr2_t WT  = 2'b10;
  localparam ctr2_t ST  = 2'b11;

  localparam logic [1:0] BTB_NONE  = 2'b00;
  localparam logic [1:0] BTB_WRITE = 2'b01;
  localparam logic [1:0] BTB_INVAL = 2'b10;

  localparam logic [1:0] MISS_NONE   = 2'b00;
  localparam logic [1:0] MISS_PC4    = 2'b01;
  localparam logic [1:0] MISS_TARGET = 2'b10;

  localparam logic [2:0] BR_NONE = 3'd0;

endpackage

// File: rtl/bht_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating counter (SNT..ST).
module sat_counter2
  import bht_predictor_pkg::*;
(
  input  ctr2_t cur,
  input  logic  inc,
  output ctr2_t nxt
);

  // NOTE: assign a default before any branch so no path leaves nxt unassigned (no latch).
  always_comb begin
    nxt = cur;
    if (inc) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped table of 2-bit counters with zero-latency mispredict resolution.
// Optional BranchCnt/MissCnt statistics are built when BHT_STATS_EN is defined.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int    ENTRIES    = 64,
  parameter ctr2_t INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFpc,
  output logic        PredTaken,
  input  logic [31:0] EXpc,
  input  logic [31:0] IDpc,
  input  logic [31:0] BrNPC,
  input  logic        BranchE,
  input  logic [2:0]  BranchTypeE,
  input  logic        StallE,
  output logic [1:0]  BTBflush,
  output logic [1:0]  PredictMiss
`ifdef BHT_STATS_EN
  ,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  ctr2_t             counters [ENTRIES];
  ctr2_t             ctr_next;
  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic [31:0]       ex_pc4;
  logic              upd_valid;

  assign if_idx    = IFpc[IDX_W+1:2];
  assign ex_idx    = EXpc[IDX_W+1:2];
  assign ex_pc4    = EXpc + 32'd4;
  assign upd_valid = (BranchTypeE != BR_NONE) && !StallE;

  // Read is from the registered array, so a same-cycle update is not visible yet.
  assign PredTaken = counters[if_idx][1];

  sat_counter2 u_sat (
    .cur (counters[ex_idx]),
    .inc (BranchE),
    .nxt (ctr_next)
  );

  // NOTE: the table is reset because predictions must be defined right after reset;
  // a plain RAM without reset would not give that guarantee.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= INIT_STATE;
    end else if (upd_valid) begin
      // NOTE: non-blocking so every reader in this edge sees the pre-update value.
      counters[ex_idx] <= ctr_next;
    end
  end

  // Resolution compares the fetched path (IDpc) against the actual outcome.
  always_comb begin
    BTBflush    = BTB_NONE;
    PredictMiss = MISS_NONE;
    if (rst && upd_valid) begin
      if (BranchE) begin
        if (IDpc != BrNPC) begin
          BTBflush    = BTB_WRITE;
          PredictMiss = MISS_TARGET;
        end
      end else if (IDpc != ex_pc4) begin
        BTBflush    = BTB_INVAL;
        PredictMiss = MISS_PC4;
      end
    end
  end

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BranchCnt <= '0;
      MissCnt   <= '0;
    end else if (upd_valid) begin
      if (BranchCnt != '1) BranchCnt <= BranchCnt + 32'd1;
      if (PredictMiss != MISS_NONE && MissCnt != '1) MissCnt <= MissCnt + 32'd1;
    end
  end
`endif

  logic unused_ifpc;
  assign unused_ifpc = ^{IFpc[31:IDX_W+2], IFpc[1:0]};

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor; define BHT_STATS_EN to also check the statistics.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IFpc, EXpc, IDpc, BrNPC;
  logic        BranchE, StallE;
  logic [2:0]  BranchTypeE;
  logic        PredTaken;
  logic [1:0]  BTBflush, PredictMiss;
`ifdef BHT_STATS_EN
  logic [31:0] BranchCnt, MissCnt;
`endif

  always #5 clk = ~clk;

  bht_predictor #(.ENTRIES(64), .INIT_STATE(2'b01)) dut (
    .clk         (clk),
    .rst         (rst),
    .IFpc        (IFpc),
    .PredTaken   (PredTaken),
    .EXpc        (EXpc),
    .IDpc        (IDpc),
    .BrNPC       (BrNPC),
    .BranchE     (BranchE),
    .BranchTypeE (BranchTypeE),
    .StallE      (StallE),
    .BTBflush    (BTBflush),
    .PredictMiss (PredictMiss)
`ifdef BHT_STATS_EN
    ,
    .BranchCnt   (BranchCnt),
    .MissCnt     (MissCnt)
`endif
  );

  typedef struct {
    string       tag;
    logic        pred;
    logic [1:0]  btb;
    logic [1:0]  miss;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t        sb [$];
  int          model [64];
  logic [31:0] m_bcnt, m_mcnt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and push what the outputs must show before the next edge.
  task automatic drive(input string tag, input logic r, input logic [31:0] ifpc,
                       input logic [31:0] expc, input logic [31:0] idpc, input logic [31:0] npc,
                       input logic be, input logic [2:0] bt, input logic st);
    exp_t        e;
    logic        upd;
    logic [31:0] pc4;
    @(negedge clk);
    rst = r; IFpc = ifpc; EXpc = expc; IDpc = idpc; BrNPC = npc;
    BranchE = be; BranchTypeE = bt; StallE = st;
    if (!r) begin
      for (int i = 0; i < 64; i++) model[i] = 1;
      m_bcnt = 0;
      m_mcnt = 0;
    end
    pc4    = expc + 32'd4;
    upd    = r && (bt != 3'd0) && !st;
    e.tag  = tag;
    e.pred = (model[ifpc[7:2]] >= 2);
    e.btb  = 2'b00;
    e.miss = 2'b00;
    if (upd) begin
      if (be && idpc != npc) begin
        e.btb = 2'b01; e.miss = 2'b10;
      end else if (!be && idpc != pc4) begin
        e.btb = 2'b10; e.miss = 2'b01;
      end
    end
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    sb.push_back(e);
    if (upd) begin
      if (be && model[expc[7:2]] < 3) model[expc[7:2]]++;
      else if (!be && model[expc[7:2]] > 0) model[expc[7:2]]--;
      m_bcnt++;
      if (e.miss != 2'b00) m_mcnt++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".pred"}, 32'(PredTaken), 32'(e.pred));
      check({e.tag, ".btb"},  32'(BTBflush),  32'(e.btb));
      check({e.tag, ".miss"}, 32'(PredictMiss), 32'(e.miss));
`ifdef BHT_STATS_EN
      check({e.tag, ".bcnt"}, BranchCnt, e.bcnt);
      check({e.tag, ".mcnt"}, MissCnt, e.mcnt);
`endif
    end
  end

  initial begin
    logic [31:0] a, b;
    rst = 1'b0; IFpc = '0; EXpc = '0; IDpc = '0; BrNPC = '0;
    BranchE = 1'b0; BranchTypeE = '0; StallE = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 1;
    m_bcnt = 0; m_mcnt = 0;

    // Reset hold with a would-be mispredict on the inputs, then release.
    drive("rst_hold", 1'b0, 32'h0, 32'h10, 32'h14, 32'h40, 1'b1, 3'd1, 1'b0);
    drive("rst_rel",  1'b1, 32'h0, 32'h0,  32'h0,  32'h0,  1'b0, 3'd0, 1'b0);

    // Training toward strongly taken, then back down.
    for (int i = 0; i < 4; i++)
      drive("train_t", 1'b1, 32'h10, 32'h10, 32'h40, 32'h40, 1'b1, 3'd1, 1'b0);
    drive("trained",  1'b1, 32'h10,  32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    drive("alias",    1'b1, 32'h110, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    drive("nt1",      1'b1, 32'h10, 32'h10, 32'h14, 32'h40, 1'b0, 3'd1, 1'b0);
    drive("nt2",      1'b1, 32'h10, 32'h10, 32'h14, 32'h40, 1'b0, 3'd1, 1'b0);
    drive("after_nt", 1'b1, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);

    // Mispredict encodings and EXpc+4 wrap-around.
    drive("miss_tgt", 1'b1, 32'h0, 32'h10, 32'h14, 32'h40, 1'b1, 3'd1, 1'b0);
    drive("miss_pc4", 1'b1, 32'h0, 32'h10, 32'h40, 32'h40, 1'b0, 3'd1, 1'b0);
    drive("wrap_ok",  1'b1, 32'hFC, 32'hFFFF_FFFC, 32'h0,   32'h8, 1'b0, 3'd2, 1'b0);
    drive("wrap_bad", 1'b1, 32'hFC, 32'hFFFF_FFFC, 32'h100, 32'h8, 1'b0, 3'd2, 1'b0);

    // Stall suppression and taken-without-branch-type.
    drive("stall",    1'b1, 32'h20, 32'h20, 32'h14, 32'h40, 1'b1, 3'd1, 1'b1);
    drive("no_type",  1'b1, 32'h20, 32'h20, 32'h14, 32'h40, 1'b1, 3'd0, 1'b0);
    drive("post_st",  1'b1, 32'h20, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);

    // Same-cycle lookup and update of one index.
    drive("same_cyc", 1'b1, 32'h20, 32'h20, 32'h40, 32'h40, 1'b1, 3'd3, 1'b0);
    drive("next_cyc", 1'b1, 32'h20, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);

    // Randomised traffic over a small PC window; the model tracks it.
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 127)) << 2;
      b = 32'($urandom_range(0, 127)) << 2;
      drive("rand", 1'b1, b, a, ($urandom_range(0, 1) == 1) ? a + 32'd4 : b,
            32'($urandom_range(0, 127)) << 2, 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    // Reset mid-stream with a pending update, then five branches with two mispredicts.
    drive("mid_rst",  1'b0, 32'h10, 32'h10, 32'h40, 32'h40, 1'b1, 3'd1, 1'b0);
    drive("mid_rel",  1'b1, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    drive("br1", 1'b1, 32'h0, 32'h10, 32'h40, 32'h40, 1'b1, 3'd1, 1'b0);
    drive("br2", 1'b1, 32'h0, 32'h10, 32'h14, 32'h40, 1'b1, 3'd1, 1'b0);
    drive("br3", 1'b1, 32'h0, 32'h10, 32'h14, 32'h40, 1'b0, 3'd1, 1'b0);
    drive("br4", 1'b1, 32'h0, 32'h10, 32'h40, 32'h40, 1'b0, 3'd1, 1'b0);
    drive("br5", 1'b1, 32'h0, 32'h20, 32'h24, 32'h40, 1'b0, 3'd2, 1'b0);
    drive("stats",    1'b1, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    drive("rst_stat", 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);
    drive("end",      1'b1, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 1'b0);

    repeat (3) @(negedge clk);
    #4;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 64, meaning the number of 2-bit counters; it SHALL be a power of two in the range 4..1024.
REQ-002 The module SHALL have parameter INIT_STATE, default 2'b01, meaning the counter value loaded at reset.
REQ-003 clk  in  1  meaning: the only clock; all state updates on its rising edge.
REQ-004 rst  in  1  meaning: reset, asynchronous and active-low.
REQ-005 IFpc  in  32  meaning: fetch-stage PC used for the prediction lookup.
REQ-006 PredTaken  out  1  meaning: prediction for IFpc; 1 = taken.
REQ-007 EXpc  in  32  meaning: PC of the instruction in EX.
REQ-008 IDpc  in  32  meaning: PC currently held in the ID register, i.e. the path actually fetched after EXpc.
REQ-009 BrNPC  in  32  meaning: resolved branch target.
REQ-010 BranchE  in  1  meaning: the branch in EX is actually taken.
REQ-011 BranchTypeE  in  3  meaning: branch type in EX; 0 = not a branch.
REQ-012 StallE  in  1  meaning: EX stalled this cycle; suppresses the update.
REQ-013 BTBflush  out  2  meaning: 10 = invalidate BTB entry for EXpc; 01 = write EXpc->BrNPC into BTB; 00 = no change.
REQ-014 PredictMiss  out  2  meaning: 10 = mispredict, redirect to BrNPC; 01 = mispredict, redirect to EXpc+4; 00 = correct.

Function
REQ-015 The index SHALL be pc[log2(ENTRIES)+1:2] for both lookup and update.
REQ-016 PredTaken SHALL be combinational: PredTaken = counter[index(IFpc)][1].
REQ-017 A valid update SHALL occur when BranchTypeE != 0 and StallE = 0.
REQ-018 On a valid update with BranchE = 1, counter[index(EXpc)] SHALL increment, saturating at 3.
REQ-019 On a valid update with BranchE = 0, counter[index(EXpc)] SHALL decrement, saturating at 0.
REQ-020 Updates SHALL take effect at the next rising clk edge.
REQ-021 A lookup of the entry being updated in the same cycle SHALL return the pre-update value.
REQ-022 Mispredict resolution SHALL be combinational with zero latency:
- BranchE = 1 and IDpc == BrNPC -> 00/00.
- BranchE = 1 and IDpc != BrNPC -> BTBflush = 01 and PredictMiss = 10.
- BranchE = 0, BranchTypeE != 0 and IDpc == EXpc+4 -> 00/00.
- BranchE = 0, BranchTypeE != 0 and IDpc != EXpc+4 -> BTBflush = 10 and PredictMiss = 01.
- BranchTypeE == 0 -> 00/00.
REQ-023 EXpc+4 SHALL be computed at 32 bits with wrap-around (0xFFFFFFFC+4 = 0).
REQ-024 While StallE = 1, BTBflush and PredictMiss SHALL be forced to 00.
REQ-025 When BranchTypeE != 0, BranchE SHALL be treated as valid; BranchE = 1 with BranchTypeE = 0 SHALL be ignored (no update, outputs 00).

Reset
REQ-026 While rst = 0, every counter SHALL asynchronously take INIT_STATE.
REQ-027 While rst = 0, BTBflush and PredictMiss SHALL be 00.
REQ-028 While rst = 0, PredTaken SHALL reflect INIT_STATE[1].
REQ-029 Reset asserted mid-operation SHALL discard any pending update.
REQ-030 The first update SHALL occur no earlier than the first rising edge after rst deasserts.

Configuration
REQ-031 With macro BHT_STATS_EN defined, the module SHALL add two 32-bit outputs, BranchCnt and MissCnt.
- BranchCnt increments on each valid update.
- MissCnt increments on each valid update with PredictMiss != 00.
- Both saturate at 0xFFFFFFFF and reset to 0.
REQ-032 Without BHT_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package SHALL hold:
- the 2-bit counter typedef and its state constants SNT = 00, WNT = 01, WT = 10, ST = 11;
- the BTBflush/PredictMiss encodings (00, 01, 10);
- the BranchTypeE "no branch" constant (0).
REQ-034 The saturating counter next-state SHALL be one sub-module, sat_counter2, instantiated once on the update path.

Verification
REQ-035 Reset: hold rst = 0, then release; lookup of IFpc = 0x00000000 -> PredTaken = 0, outputs 00/00.
REQ-036 Training: four taken updates at EXpc = 0x00000010 -> counter = 3 (saturated); IFpc = 0x00000010 -> PredTaken = 1. Then one not-taken update -> PredTaken still 1; a second not-taken update -> PredTaken = 0.
REQ-037 Aliasing: with ENTRIES = 64, train EXpc = 0x00000010 taken; IFpc = 0x00000110 (same index) -> PredTaken = 1.
REQ-038 Mispredicts:
- BranchE = 1, BrNPC = 0x40, IDpc = 0x14 -> BTBflush = 01, PredictMiss = 10.
- BranchE = 0, BranchTypeE = 1, EXpc = 0x10, IDpc = 0x40 -> BTBflush = 10, PredictMiss = 01.
REQ-039 Stall/same-cycle: update with StallE = 1 -> counter unchanged and outputs 00/00. Same-cycle lookup and update of one index -> old value returned; new value visible next cycle.
REQ-040 With BHT_STATS_EN, five branches with two mispredicts -> BranchCnt = 5, MissCnt = 2; asserting rst = 0 mid-stream -> both counters = 0 immediately.
